// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: shift opcodes and FSM states.
package seq_shifter_pkg;

    // Shift opcodes (3-bit function field); 101..111 are pass-through.
    localparam logic [2:0] FN_ROL = 3'b000;
    localparam logic [2:0] FN_ROR = 3'b001;
    localparam logic [2:0] FN_SHL = 3'b010;
    localparam logic [2:0] FN_SHR = 3'b011;
    localparam logic [2:0] FN_ASR = 3'b100;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-position shift/rotate step with carry-out.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [2:0]       i_func,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry
);

    // One position of the selected operation; unknown opcodes pass data through.
    always_comb begin
        o_data  = i_data;
        o_carry = 1'b0;
        case (i_func)
            FN_ROL: begin
                o_data  = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
                o_carry = i_data[WIDTH-1];
            end
            FN_ROR: begin
                o_data  = {i_data[0], i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            FN_SHL: begin
                o_data  = {i_data[WIDTH-2:0], 1'b0};
                o_carry = i_data[WIDTH-1];
            end
            FN_SHR: begin
                o_data  = {1'b0, i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            FN_ASR: begin
                o_data  = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
                o_carry = i_data[0];
            end
            default: begin
                o_data  = i_data;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one (or two, with SEQ_SHIFTER_DUAL_STEP_EN
// defined) positions per clock under a start/done handshake. The last bit
// shifted out is reported on carry.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       func,
    input  logic [CNT_W-1:0] amount,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_func;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;

    logic [WIDTH-1:0] w_step1_data;
    logic             w_step1_carry;

    // First step always operates on the current result register.
    shift_step #(.WIDTH(WIDTH)) u_step1 (
        .i_data  (r_out),
        .i_func  (r_func),
        .o_data  (w_step1_data),
        .o_carry (w_step1_carry)
    );

`ifdef SEQ_SHIFTER_DUAL_STEP_EN
    logic [WIDTH-1:0] w_step2_data;
    logic             w_step2_carry;

    // Second step chained after the first for two positions per cycle.
    shift_step #(.WIDTH(WIDTH)) u_step2 (
        .i_data  (w_step1_data),
        .i_func  (r_func),
        .o_data  (w_step2_data),
        .o_carry (w_step2_carry)
    );
`endif

    // Controller, position counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_func  <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_out   <= a;
                        r_count <= amount;
                        r_func  <= func;
                        r_carry <= 1'b0;
                        // Zero-step work (amount 0 or pass-through) skips SHIFT.
                        if (amount != '0 && func <= FN_ASR)
                            r_state <= SHIFT;
                        else
                            r_state <= DONE;
                    end
                end
                SHIFT: begin
`ifdef SEQ_SHIFTER_DUAL_STEP_EN
                    if (r_count >= CNT_W'(2)) begin
                        r_out   <= w_step2_data;
                        r_carry <= w_step2_carry;
                        r_count <= r_count - CNT_W'(2);
                        if (r_count == CNT_W'(2))
                            r_state <= DONE;
                    end else begin
                        r_out   <= w_step1_data;
                        r_carry <= w_step1_carry;
                        r_count <= r_count - CNT_W'(1);
                        r_state <= DONE;
                    end
`else
                    r_out   <= w_step1_data;
                    r_carry <= w_step1_carry;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1))
                        r_state <= DONE;
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == SHIFT) || (r_state == DONE);
    assign done  = (r_state == DONE);
    assign out   = r_out;
    assign carry = r_carry;

endmodule
